// File: rtl/load_store_unit.sv
// RV32I load/store unit: one transaction at a time over a single-beat req/ack bus.
// Optional REQ-phase timeout enabled by defining LSU_TIMEOUT_EN.
`timescale 1ns/1ps

module load_store_unit #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] ReadData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  if (TIMEOUT_CYC < 1 || (2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cfg_check
    $error("load_store_unit: TIMEOUT_CYC must be >= 1 and below 2**CNT_W");
  end

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
`endif

  // Size 11 is never legal; funct3[2] only exists for sub-word loads.
  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    if (f3[2] && (we || f3[1:0] == 2'b10)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic we, input logic [2:0] f3,
                                         input logic [1:0] a);
    logic [3:0] be;
    if (!we) be = 4'b1111;
    else begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << a;
        2'b01:   be = 4'b0011 << a;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [2:0] f3,
                                                 input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [31:0] lane;
    logic [31:0] r;
    lane = rdata >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{lane[7]}}, lane[7:0]};
      3'b001:  r = {{16{lane[15]}}, lane[15:0]};
      3'b100:  r = {24'h0, lane[7:0]};
      3'b101:  r = {16'h0, lane[15:0]};
      default: r = lane;
    endcase
    return r;
  endfunction

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign mem_req    = (state == ST_REQ);

  // Bus fields read as zero outside REQ so an aborted or idle bus is quiet.
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? be_q : 4'h0;
  assign mem_wdata = (mem_req & we_q) ? wdata_q : 32'h0;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr_q   <= 32'h0;
      funct3_q <= 3'h0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      ReadData <= 32'h0;
      resp_err <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= ALUResult;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            be_q     <= byte_en(req_we, req_funct3, ALUResult[1:0]);
            wdata_q  <= lane_replicate(req_funct3, WriteData);
`ifdef LSU_TIMEOUT_EN
            cnt      <= '0;
`endif
            if (is_legal(req_we, req_funct3, ALUResult[1:0])) begin
              state <= ST_REQ;
            end else begin
              state    <= ST_RESP;
              resp_err <= 1'b1;
              ReadData <= 32'h0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state    <= ST_RESP;
            resp_err <= 1'b0;
            ReadData <= we_q ? 32'h0 : load_extract(funct3_q, addr_q[1:0], mem_rdata);
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state    <= ST_RESP;
            resp_err <= 1'b1;
            ReadData <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads/stores, alignment errors, wait states,
// idle ack, async reset abort, and the REQ timeout when LSU_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] ALUResult, WriteData;
  logic        resp_valid, resp_err;
  logic [31:0] ReadData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int vectors     = 0;
  int miscompares = 0;
  int resp_count  = 0;
  int ops_done    = 0;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .ReadData   (ReadData),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && resp_valid === 1'b1) resp_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request; a legal one is acked after `delay` extra REQ cycles.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] rdata, input logic legal,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd, input logic hold_valid);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; ALUResult = addr; WriteData = wd;
    check({tag, " ready"}, req_ready, 1'b1);
    @(posedge clk); #1;
    if (!hold_valid) req_valid = 1'b0;
    if (legal) begin
      for (int i = 0; i <= delay; i++) begin
        check({tag, " mem_req"}, mem_req, 1'b1);
        check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, " mem_be"}, mem_be, exp_be);
        check({tag, " mem_we"}, mem_we, we);
        if (we) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, " ready busy"}, req_ready, 1'b0);
        check({tag, " no early resp"}, resp_valid, 1'b0);
        if (i == delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
        @(posedge clk); #1;
      end
      mem_ack = 1'b0; req_valid = 1'b0;
      check({tag, " resp_valid"}, resp_valid, 1'b1);
      check({tag, " resp_err"}, resp_err, 1'b0);
      check({tag, " ReadData"}, ReadData, exp_rd);
      check({tag, " mem_req off"}, mem_req, 1'b0);
    end else begin
      check({tag, " no mem_req"}, mem_req, 1'b0);
      check({tag, " resp_valid"}, resp_valid, 1'b1);
      check({tag, " resp_err"}, resp_err, 1'b1);
      check({tag, " ReadData"}, ReadData, 32'h0);
    end
    ops_done++;
    @(posedge clk); #1;
    check({tag, " pulse ends"}, resp_valid, 1'b0);
    check({tag, " back idle"}, req_ready, 1'b1);
    check({tag, " ReadData held"}, ReadData, legal ? exp_rd : 32'h0);
    check({tag, " resp count"}, resp_count, ops_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
    ALUResult = 32'h0; WriteData = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #2;
    check("rst mem_req", mem_req, 1'b0);
    check("rst resp_valid", resp_valid, 1'b0);
    check("rst mem_be", mem_be, 4'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst ReadData", ReadData, 32'h0);
    check("rst resp_err", resp_err, 1'b0);
    #10 rst_n = 1'b1;
    #1 check("rst ready", req_ready, 1'b1);

    //      tag      we  f3      addr         wdata        dly rdata        legal be       wdata        ReadData     hold
    run_op("LW",     0, 3'b010, 32'h100,     32'h0,       0, 32'hDEADBEEF, 1, 4'b1111, 32'h0,       32'hDEADBEEF, 0);
    run_op("LB",     0, 3'b000, 32'h103,     32'h0,       0, 32'h80FF0000, 1, 4'b1111, 32'h0,       32'hFFFFFF80, 0);
    run_op("LBU",    0, 3'b100, 32'h103,     32'h0,       0, 32'h80FF0000, 1, 4'b1111, 32'h0,       32'h00000080, 0);
    run_op("LH",     0, 3'b001, 32'h102,     32'h0,       1, 32'h80010000, 1, 4'b1111, 32'h0,       32'hFFFF8001, 0);
    run_op("LHU",    0, 3'b101, 32'h102,     32'h0,       0, 32'h80010000, 1, 4'b1111, 32'h0,       32'h00008001, 0);
    run_op("SH",     1, 3'b001, 32'h202,     32'h1234ABCD, 0, 32'h0,       1, 4'b1100, 32'hABCDABCD, 32'h0,       0);
    run_op("SB",     1, 3'b000, 32'h201,     32'h7777775A, 0, 32'h0,       1, 4'b0010, 32'h5A5A5A5A, 32'h0,       0);
    run_op("LW mis", 0, 3'b010, 32'h102,     32'h0,       0, 32'h0,        0, 4'h0,    32'h0,       32'h0,        0);
    run_op("LH mis", 0, 3'b001, 32'h101,     32'h0,       0, 32'h0,        0, 4'h0,    32'h0,       32'h0,        0);
    run_op("f3 011", 0, 3'b011, 32'h100,     32'h0,       0, 32'h0,        0, 4'h0,    32'h0,       32'h0,        0);
    run_op("SBU",    1, 3'b100, 32'h100,     32'h0,       0, 32'h0,        0, 4'h0,    32'h0,       32'h0,        0);
    run_op("SW wait",1, 3'b010, 32'h300,     32'hCAFEF00D, 5, 32'h0,       1, 4'b1111, 32'hCAFEF00D, 32'h0,       1);
    run_op("LB pos", 0, 3'b000, 32'h100,     32'h0,       2, 32'hFFFFFF7F, 1, 4'b1111, 32'h0,       32'h0000007F, 0);

    // A stray ack while idle must not start or finish anything.
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("idle ack mem_req", mem_req, 1'b0);
    check("idle ack resp", resp_valid, 1'b0);
    check("idle ack ReadData", ReadData, 32'h0000007F);
    @(posedge clk); #1;
    check("idle ack count", resp_count, ops_done);

    // Reset while REQ is outstanding aborts the op with no response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; ALUResult = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort mem_req before", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort mem_req async", mem_req, 1'b0);
    check("abort resp_valid", resp_valid, 1'b0);
    check("abort mem_be", mem_be, 4'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort ready", req_ready, 1'b1);
    check("abort count", resp_count, ops_done);

`ifdef LSU_TIMEOUT_EN
    begin
      int req_cycles = 0;
      int waited     = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; ALUResult = 32'h400;
      @(posedge clk); #1;
      req_valid = 1'b0;
      while (resp_valid !== 1'b1 && waited < 40) begin
        if (mem_req === 1'b1) req_cycles++;
        waited++;
        @(posedge clk); #1;
      end
      ops_done++;
      check("tmo resp_valid", resp_valid, 1'b1);
      check("tmo req cycles", req_cycles, 16);
      check("tmo resp_err", resp_err, 1'b1);
      check("tmo ReadData", ReadData, 32'h0);
      check("tmo mem_req off", mem_req, 1'b0);
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(posedge clk); #1;
      check("tmo late ack count", resp_count, ops_done);
      check("tmo late ack ReadData", ReadData, 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
